// File: rtl/serial_adder.sv
// Digit-serial adder: {cout, sum} = a + b + cin, DIGIT bits per clock over WIDTH/DIGIT cycles,
// with ready/valid handshakes on both sides and a two's-complement overflow flag.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] psum_q, psum_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [DIGIT:0]   rc;
    logic [DIGIT-1:0] dig_sum;
    logic [WIDTH+DIGIT-1:0] psum_cat;

    // Ripple chain across one digit; rc[DIGIT-1] is the carry into the digit's top bit,
    // which on the last digit is the carry into bit WIDTH-1 needed for overflow.
    assign rc[0] = carry_q;
    generate
        for (genvar gi = 0; gi < DIGIT; gi++) begin : g_ripple
            assign dig_sum[gi] = a_q[gi] ^ b_q[gi] ^ rc[gi];
            assign rc[gi+1]    = (a_q[gi] & b_q[gi]) | (rc[gi] & (a_q[gi] ^ b_q[gi]));
        end
    endgenerate

    assign psum_cat = {dig_sum, psum_q};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        psum_d  = psum_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    psum_d  = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                psum_d  = psum_cat[WIDTH+DIGIT-1:DIGIT];
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = rc[DIGIT];
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(N - 1)) begin
                    sum_d   = psum_cat[WIDTH+DIGIT-1:DIGIT];
                    cout_d  = rc[DIGIT];
                    ovf_d   = rc[DIGIT-1] ^ rc[DIGIT];
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            psum_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            psum_q  <= psum_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // in_ready is masked by rst so upstream never sees a ready block while reset is held.
    assign in_ready  = (state_q == S_IDLE) && !rst;
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_RUN) || (state_q == S_DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: directed scenarios on 8-bit instances plus a randomized sweep
// over 16-bit instances of every DIGIT, all checked against a plain-arithmetic model.
module tb_serial_adder;

    localparam int NI = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        in_valid_s  [NI];
    logic        out_ready_s [NI];
    logic        cin_s       [NI];
    logic [15:0] a_s         [NI];
    logic [15:0] b_s         [NI];
    wire         in_ready_w  [NI];
    wire         out_valid_w [NI];
    wire         cout_w      [NI];
    wire         ovf_w       [NI];
    wire         busy_w      [NI];
    wire  [15:0] sum_w       [NI];

    int errors = 0;
    int checks = 0;

    serial_adder #(.WIDTH(8), .DIGIT(1)) u_w8d1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_s[0]), .in_ready(in_ready_w[0]),
        .a(a_s[0][7:0]), .b(b_s[0][7:0]), .cin(cin_s[0]),
        .out_valid(out_valid_w[0]), .out_ready(out_ready_s[0]),
        .sum(sum_w[0][7:0]), .cout(cout_w[0]), .ovf(ovf_w[0]), .busy(busy_w[0])
    );

    serial_adder #(.WIDTH(8), .DIGIT(4)) u_w8d4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_s[1]), .in_ready(in_ready_w[1]),
        .a(a_s[1][7:0]), .b(b_s[1][7:0]), .cin(cin_s[1]),
        .out_valid(out_valid_w[1]), .out_ready(out_ready_s[1]),
        .sum(sum_w[1][7:0]), .cout(cout_w[1]), .ovf(ovf_w[1]), .busy(busy_w[1])
    );

    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_w16
            serial_adder #(.WIDTH(16), .DIGIT(1 << gi)) u_dut (
                .clk(clk), .rst(rst),
                .in_valid(in_valid_s[gi+2]), .in_ready(in_ready_w[gi+2]),
                .a(a_s[gi+2]), .b(b_s[gi+2]), .cin(cin_s[gi+2]),
                .out_valid(out_valid_w[gi+2]), .out_ready(out_ready_s[gi+2]),
                .sum(sum_w[gi+2]), .cout(cout_w[gi+2]), .ovf(ovf_w[gi+2]), .busy(busy_w[gi+2])
            );
        end
    endgenerate

    function automatic int inst_w(input int k);
        return (k < 2) ? 8 : 16;
    endfunction

    function automatic int inst_d(input int k);
        if (k == 0) return 1;
        if (k == 1) return 4;
        return 1 << (k - 2);
    endfunction

    function automatic logic [15:0] mask(input int w);
        return (w == 16) ? 16'hFFFF : 16'h00FF;
    endfunction

    // Reference: whole-word addition; signed overflow when both operands share a sign
    // and the result's sign differs from it.
    function automatic logic [17:0] ref_add(input int w, input logic [15:0] av, input logic [15:0] bv,
                                            input logic cv);
        logic [16:0] full;
        logic [15:0] m;
        logic [15:0] s;
        logic        co;
        logic        ov;
        m    = mask(w);
        full = {1'b0, av & m} + {1'b0, bv & m} + {16'b0, cv};
        s    = full[15:0] & m;
        co   = full[w];
        ov   = (av[w-1] == bv[w-1]) && (s[w-1] != av[w-1]);
        return {ov, co, s};
    endfunction

    // Presents one operand set at a falling edge, then waits (bounded) for out_valid.
    // Returns at the falling edge where out_valid is first seen; lat counts rising edges
    // after the accept edge.
    task automatic do_op(input int k, input logic [15:0] av, input logic [15:0] bv, input logic cv,
                         output logic [15:0] s, output logic co, output logic ov,
                         output int lat);
        @(negedge clk);
        in_valid_s[k] = 1'b1;
        a_s[k]        = av & mask(inst_w(k));
        b_s[k]        = bv & mask(inst_w(k));
        cin_s[k]      = cv;
        @(negedge clk);
        in_valid_s[k] = 1'b0;
        a_s[k]        = 16'($urandom);
        b_s[k]        = 16'($urandom);
        cin_s[k]      = 1'($urandom);
        lat = 0;
        while (out_valid_w[k] !== 1'b1 && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        s  = sum_w[k] & mask(inst_w(k));
        co = cout_w[k];
        ov = ovf_w[k];
        $display("txn inst=%0d W=%0d D=%0d a=%h b=%h cin=%b -> sum=%h cout=%b ovf=%b lat=%0d",
                 k, inst_w(k), inst_d(k), av & mask(inst_w(k)), bv & mask(inst_w(k)), cv, s, co, ov, lat);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready_w[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready_during_rst: got %b expected 0", in_ready_w[0]);
        end
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            checks++;
            if (out_valid_w[k] !== 1'b0) begin
                errors++; $display("FAIL reset_out_valid[%0d]: got %b expected 0", k, out_valid_w[k]);
            end
            checks++;
            if ((sum_w[k] & mask(inst_w(k))) !== 16'h0) begin
                errors++; $display("FAIL reset_sum[%0d]: got %h expected 0", k, sum_w[k] & mask(inst_w(k)));
            end
            checks++;
            if (cout_w[k] !== 1'b0) begin
                errors++; $display("FAIL reset_cout[%0d]: got %b expected 0", k, cout_w[k]);
            end
            checks++;
            if (ovf_w[k] !== 1'b0) begin
                errors++; $display("FAIL reset_ovf[%0d]: got %b expected 0", k, ovf_w[k]);
            end
            checks++;
            if (busy_w[k] !== 1'b0) begin
                errors++; $display("FAIL reset_busy[%0d]: got %b expected 0", k, busy_w[k]);
            end
            checks++;
            if (in_ready_w[k] !== 1'b1) begin
                errors++; $display("FAIL reset_in_ready[%0d]: got %b expected 1", k, in_ready_w[k]);
            end
        end
    endtask

    task automatic test_unsigned_carry();
        logic [17:0] exp;
        logic [15:0] s;
        logic        co, ov;
        int          lat;
        exp = ref_add(8, 16'h00FF, 16'h0001, 1'b0);
        do_op(0, 16'h00FF, 16'h0001, 1'b0, s, co, ov, lat);
        checks++;
        if (lat !== 8) begin errors++; $display("FAIL carry_latency: got %0d expected 8", lat); end
        checks++;
        if (s !== exp[15:0]) begin errors++; $display("FAIL carry_sum: got %h expected %h", s, exp[15:0]); end
        checks++;
        if (co !== exp[16]) begin errors++; $display("FAIL carry_cout: got %b expected %b", co, exp[16]); end
        checks++;
        if (ov !== exp[17]) begin errors++; $display("FAIL carry_ovf: got %b expected %b", ov, exp[17]); end
    endtask

    task automatic test_signed_overflow();
        logic [17:0] exp;
        logic [15:0] s;
        logic        co, ov;
        int          lat;
        exp = ref_add(8, 16'h007F, 16'h0001, 1'b0);
        do_op(0, 16'h007F, 16'h0001, 1'b0, s, co, ov, lat);
        checks++;
        if (lat !== 8) begin errors++; $display("FAIL ovf_latency: got %0d expected 8", lat); end
        checks++;
        if (s !== exp[15:0]) begin errors++; $display("FAIL ovf_sum: got %h expected %h", s, exp[15:0]); end
        checks++;
        if (co !== exp[16]) begin errors++; $display("FAIL ovf_cout: got %b expected %b", co, exp[16]); end
        checks++;
        if (ov !== exp[17]) begin errors++; $display("FAIL ovf_flag: got %b expected %b", ov, exp[17]); end
    endtask

    task automatic test_multi_digit();
        logic [17:0] exp;
        logic [15:0] s;
        logic        co, ov;
        int          lat;
        exp = ref_add(8, 16'h00A5, 16'h005B, 1'b1);
        do_op(1, 16'h00A5, 16'h005B, 1'b1, s, co, ov, lat);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL digit4_latency: got %0d expected 2", lat); end
        checks++;
        if (s !== exp[15:0]) begin errors++; $display("FAIL digit4_sum: got %h expected %h", s, exp[15:0]); end
        checks++;
        if (co !== exp[16]) begin errors++; $display("FAIL digit4_cout: got %b expected %b", co, exp[16]); end
        checks++;
        if (ov !== exp[17]) begin errors++; $display("FAIL digit4_ovf: got %b expected %b", ov, exp[17]); end
    endtask

    task automatic test_backpressure();
        logic [17:0] exp;
        logic [15:0] s;
        logic        co, ov;
        int          lat;
        int          extra;
        exp = ref_add(8, 16'h003C, 16'h004A, 1'b1);
        out_ready_s[0] = 1'b0;
        do_op(0, 16'h003C, 16'h004A, 1'b1, s, co, ov, lat);
        checks++;
        if (lat !== 8) begin errors++; $display("FAIL bp_latency: got %0d expected 8", lat); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            in_valid_s[0] = (c == 2);
            a_s[0]        = 16'h00FF;
            b_s[0]        = 16'h00FF;
            checks++;
            if (out_valid_w[0] !== 1'b1) begin
                errors++; $display("FAIL bp_out_valid_held c=%0d: got %b expected 1", c, out_valid_w[0]);
            end
            checks++;
            if (in_ready_w[0] !== 1'b0) begin
                errors++; $display("FAIL bp_in_ready c=%0d: got %b expected 0", c, in_ready_w[0]);
            end
            checks++;
            if ((sum_w[0] & 16'h00FF) !== exp[15:0] || cout_w[0] !== exp[16] || ovf_w[0] !== exp[17]) begin
                errors++;
                $display("FAIL bp_result_held c=%0d: got sum=%h cout=%b ovf=%b expected sum=%h cout=%b ovf=%b",
                         c, sum_w[0] & 16'h00FF, cout_w[0], ovf_w[0], exp[15:0], exp[16], exp[17]);
            end
        end
        in_valid_s[0]  = 1'b0;
        out_ready_s[0] = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid_w[0] !== 1'b0 || busy_w[0] !== 1'b0 || in_ready_w[0] !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: got out_valid=%b busy=%b in_ready=%b expected 0 0 1",
                     out_valid_w[0], busy_w[0], in_ready_w[0]);
        end
        extra = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid_w[0] === 1'b1 || busy_w[0] === 1'b1) extra++;
        end
        checks++;
        if (extra !== 0) begin
            errors++; $display("FAIL bp_single_result: got %0d busy/valid cycles after release expected 0", extra);
        end
    endtask

    task automatic test_reset_mid_run();
        int rises;
        @(negedge clk);
        in_valid_s[0] = 1'b1;
        a_s[0]        = 16'h0012;
        b_s[0]        = 16'h0034;
        cin_s[0]      = 1'b0;
        @(negedge clk);
        in_valid_s[0] = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy_w[0] !== 1'b1) begin
            errors++; $display("FAIL midrst_busy_before: got %b expected 1", busy_w[0]);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (busy_w[0] !== 1'b0) begin
            errors++; $display("FAIL midrst_busy_immediate: got %b expected 0", busy_w[0]);
        end
        checks++;
        if (in_ready_w[0] !== 1'b0) begin
            errors++; $display("FAIL midrst_in_ready_in_rst: got %b expected 0", in_ready_w[0]);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready_w[0] !== 1'b1) begin
            errors++; $display("FAIL midrst_in_ready_after: got %b expected 1", in_ready_w[0]);
        end
        checks++;
        if ((sum_w[0] & 16'h00FF) !== 16'h0 || cout_w[0] !== 1'b0 || ovf_w[0] !== 1'b0) begin
            errors++;
            $display("FAIL midrst_outputs_cleared: got sum=%h cout=%b ovf=%b expected 0 0 0",
                     sum_w[0] & 16'h00FF, cout_w[0], ovf_w[0]);
        end
        rises = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid_w[0] === 1'b1) rises++;
        end
        checks++;
        if (rises !== 0) begin
            errors++; $display("FAIL midrst_no_out_valid: got %0d valid cycles expected 0", rises);
        end
    endtask

    task automatic test_back_to_back();
        logic [17:0] exp;
        logic [15:0] s;
        logic        co, ov;
        int          lat;
        for (int t = 0; t < 2; t++) begin
            logic [15:0] av, bv;
            av  = 16'($urandom);
            bv  = 16'($urandom);
            exp = ref_add(16, av, bv, t[0]);
            do_op(4, av, bv, t[0], s, co, ov, lat);
            checks++;
            if (lat !== 4 || s !== exp[15:0] || co !== exp[16] || ov !== exp[17]) begin
                errors++;
                $display("FAIL b2b_result t=%0d: got lat=%0d sum=%h cout=%b ovf=%b expected lat=4 sum=%h cout=%b ovf=%b",
                         t, lat, s, co, ov, exp[15:0], exp[16], exp[17]);
            end
            checks++;
            if (in_ready_w[4] !== 1'b0) begin
                errors++; $display("FAIL b2b_in_ready_in_done t=%0d: got %b expected 0", t, in_ready_w[4]);
            end
            @(negedge clk);
            checks++;
            if (in_ready_w[4] !== 1'b1 || out_valid_w[4] !== 1'b0) begin
                errors++;
                $display("FAIL b2b_turnaround t=%0d: got in_ready=%b out_valid=%b expected 1 0",
                         t, in_ready_w[4], out_valid_w[4]);
            end
        end
    endtask

    task automatic test_random_sweep();
        logic [15:0] edge_a [6];
        logic [15:0] edge_b [6];
        logic [17:0] exp;
        logic [15:0] s, av, bv;
        logic        co, ov, cv;
        int          lat, k, n_exp;
        edge_a = '{16'hFFFF, 16'h7FFF, 16'h8000, 16'h0000, 16'h8000, 16'h7FFF};
        edge_b = '{16'h0001, 16'h0001, 16'hFFFF, 16'h0000, 16'h8000, 16'h0000};
        for (int i = 0; i < 1000; i++) begin
            k = 2 + int'($urandom_range(4));
            if (i < 30) begin
                av = edge_a[i % 6];
                bv = edge_b[i % 6];
                cv = 1'(i / 6);
                k  = 2 + (i % 5);
            end else begin
                av = 16'($urandom);
                bv = 16'($urandom);
                cv = 1'($urandom);
            end
            n_exp = 16 / inst_d(k);
            exp   = ref_add(16, av, bv, cv);
            do_op(k, av, bv, cv, s, co, ov, lat);
            checks++;
            if (lat !== n_exp) begin
                errors++; $display("FAIL sweep_latency i=%0d D=%0d: got %0d expected %0d", i, inst_d(k), lat, n_exp);
            end
            checks++;
            if (s !== exp[15:0]) begin
                errors++; $display("FAIL sweep_sum i=%0d D=%0d: got %h expected %h", i, inst_d(k), s, exp[15:0]);
            end
            checks++;
            if (co !== exp[16]) begin
                errors++; $display("FAIL sweep_cout i=%0d D=%0d: got %b expected %b", i, inst_d(k), co, exp[16]);
            end
            checks++;
            if (ov !== exp[17]) begin
                errors++; $display("FAIL sweep_ovf i=%0d D=%0d: got %b expected %b", i, inst_d(k), ov, exp[17]);
            end
        end
    endtask

    initial begin
        for (int k = 0; k < NI; k++) begin
            in_valid_s[k]  = 1'b0;
            out_ready_s[k] = 1'b1;
            cin_s[k]       = 1'b0;
            a_s[k]         = 16'h0;
            b_s[k]         = 16'h0;
        end
        test_reset();
        test_unsigned_carry();
        test_signed_overflow();
        test_multi_digit();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        test_random_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
